// File: rtl/slot_txrx_ctrl_pkg.sv
// rtl/slot_txrx_ctrl_pkg.sv - shared state encodings, timing constants and helpers
package slot_txrx_ctrl_pkg;

    localparam int DEF_CNT_W      = 12;
    localparam int DEF_MAX_PKT_US = 3125;
    localparam int SLOT_US        = 625;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_PLL_TX    = 3'd1;
    localparam state_t ST_TX        = 3'd2;
    localparam state_t ST_PLL_RX    = 3'd3;
    localparam state_t ST_RX_SEARCH = 3'd4;
    localparam state_t ST_RX_ACTIVE = 3'd5;

    // Slave transmits in the half of the CLK[1] period the master receives in.
    function automatic logic next_is_tx(input logic is_master, input logic clk_bit1);
        return is_master ? clk_bit1 : !clk_bit1;
    endfunction

endpackage

// File: rtl/slot_txrx_ctrl_if.sv
// rtl/slot_txrx_ctrl_if.sv - slot timing inputs and radio control outputs of the slot controller
interface slot_txrx_ctrl_if;

    logic        regi_isMaster;
    logic        conn_en;
    logic        p_1us;
    logic        fkset_p;
    logic [1:0]  clk_bits;
    logic        tx_slot_start_p;
    logic        rx_slot_start_p;
    logic        tx_req;
    logic [11:0] tx_len_us;
    logic        rx_sync_p;
    logic        rx_done_p;
    logic [9:0]  regi_rxwin_us;

    logic        pll_load_p;
    logic        pll_is_tx;
    logic        tx_en;
    logic        rx_en;
    logic        tx_start_p;
    logic        tx_done_p;
    logic        rx_timeout_p;
    logic        rx_abort_p;
    logic [2:0]  state;

    modport master (
        output regi_isMaster, conn_en, p_1us, fkset_p, clk_bits,
               tx_slot_start_p, rx_slot_start_p, tx_req, tx_len_us,
               rx_sync_p, rx_done_p, regi_rxwin_us,
        input  pll_load_p, pll_is_tx, tx_en, rx_en, tx_start_p, tx_done_p,
               rx_timeout_p, rx_abort_p, state
    );

    modport slave (
        input  regi_isMaster, conn_en, p_1us, fkset_p, clk_bits,
               tx_slot_start_p, rx_slot_start_p, tx_req, tx_len_us,
               rx_sync_p, rx_done_p, regi_rxwin_us,
        output pll_load_p, pll_is_tx, tx_en, rx_en, tx_start_p, tx_done_p,
               rx_timeout_p, rx_abort_p, state
    );

endinterface

// File: rtl/slot_txrx_ctrl_us_downcnt.sv
// rtl/slot_txrx_ctrl_us_downcnt.sv - loadable 1us down-counter saturating at zero
module slot_txrx_ctrl_us_downcnt #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         tick_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (tick_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Flags the tick that brings the count to zero so the owner can leave on that tick.
    assign expire_o = tick_i && !load_i && (cnt_q <= W'(1));

endmodule

// File: rtl/slot_txrx_ctrl.sv
// rtl/slot_txrx_ctrl.sv - per-slot PLL/TX/RX radio control for a connection
module slot_txrx_ctrl
    import slot_txrx_ctrl_pkg::*;
#(
    parameter int MAX_PKT_US = DEF_MAX_PKT_US,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic              clk_6M,
    input  logic              rst,
    slot_txrx_ctrl_if.slave   bus
);

    localparam logic [CNT_W-1:0] MAX_LEN   = CNT_W'(MAX_PKT_US);
    localparam logic [CNT_W-1:0] WDOG_LEN  = CNT_W'(SLOT_US);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  len_q, len_d;

    logic              load0, load1;
    logic [CNT_W-1:0]  val0, val1;
    logic              exp0, exp1;

    logic              fk_full;
    logic              tx_go;
    logic [CNT_W-1:0]  len_in;
    logic [CNT_W-1:0]  len_sat;
    logic [CNT_W-1:0]  win_val;

    logic              tx_fin, rx_to, rx_ab;

    logic pll_load_p_q, pll_load_p_d;
    logic pll_is_tx_q, pll_is_tx_d;
    logic tx_en_q, tx_en_d;
    logic rx_en_q, rx_en_d;
    logic tx_start_p_q, tx_start_p_d;
    logic tx_done_p_q, tx_done_p_d;
    logic rx_timeout_p_q, rx_timeout_p_d;
    logic rx_abort_p_q, rx_abort_p_d;

    assign fk_full = bus.fkset_p & bus.clk_bits[0];
    assign len_in  = CNT_W'(bus.tx_len_us);
    assign len_sat = (len_in > MAX_LEN) ? MAX_LEN : len_in;
    assign win_val = (bus.regi_rxwin_us == 10'd0) ? CNT_W'(1) : CNT_W'(bus.regi_rxwin_us);
    assign tx_go   = fk_full & next_is_tx(bus.regi_isMaster, bus.clk_bits[1])
                   & bus.tx_req & (bus.tx_len_us != 12'd0);

    // Counter 0 serves watchdog, TX length and RX guard; those phases never overlap.
    slot_txrx_ctrl_us_downcnt #(.W(CNT_W)) u_cnt_main (
        .clk        (clk_6M),
        .rst        (rst),
        .load_i     (load0),
        .load_val_i (val0),
        .tick_i     (bus.p_1us),
        .expire_o   (exp0)
    );

    slot_txrx_ctrl_us_downcnt #(.W(CNT_W)) u_cnt_win (
        .clk        (clk_6M),
        .rst        (rst),
        .load_i     (load1),
        .load_val_i (val1),
        .tick_i     (bus.p_1us),
        .expire_o   (exp1)
    );

    always_ff @(posedge clk_6M) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            len_q          <= '0;
            pll_load_p_q   <= 1'b0;
            pll_is_tx_q    <= 1'b0;
            tx_en_q        <= 1'b0;
            rx_en_q        <= 1'b0;
            tx_start_p_q   <= 1'b0;
            tx_done_p_q    <= 1'b0;
            rx_timeout_p_q <= 1'b0;
            rx_abort_p_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            pll_load_p_q   <= pll_load_p_d;
            pll_is_tx_q    <= pll_is_tx_d;
            tx_en_q        <= tx_en_d;
            rx_en_q        <= rx_en_d;
            tx_start_p_q   <= tx_start_p_d;
            tx_done_p_q    <= tx_done_p_d;
            rx_timeout_p_q <= rx_timeout_p_d;
            rx_abort_p_q   <= rx_abort_p_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        load0   = 1'b0;
        val0    = '0;
        load1   = 1'b0;
        val1    = '0;
        tx_fin  = 1'b0;
        rx_to   = 1'b0;
        rx_ab   = 1'b0;
        if (!bus.conn_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tx_go) begin
                        state_d = ST_PLL_TX;
                        len_d   = len_sat;
                        load0   = 1'b1;
                        val0    = WDOG_LEN;
                    end else if (fk_full) begin
                        state_d = ST_PLL_RX;
                        load0   = 1'b1;
                        val0    = WDOG_LEN;
                    end
                end
                ST_PLL_TX: begin
                    if (bus.tx_slot_start_p) begin
                        state_d = ST_TX;
                        load0   = 1'b1;
                        val0    = len_q;
                    end else if (exp0) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_TX: begin
                    if (exp0) begin
                        state_d = ST_IDLE;
                        tx_fin  = 1'b1;
                    end
                end
                ST_PLL_RX: begin
                    if (bus.rx_slot_start_p) begin
                        state_d = ST_RX_SEARCH;
                        load1   = 1'b1;
                        val1    = win_val;
                    end else if (exp0) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RX_SEARCH: begin
                    if (bus.rx_sync_p) begin
                        state_d = ST_RX_ACTIVE;
                        load0   = 1'b1;
                        val0    = MAX_LEN;
                    end else if (exp1) begin
                        state_d = ST_IDLE;
                        rx_to   = 1'b1;
                    end
                end
                ST_RX_ACTIVE: begin
                    if (bus.rx_done_p) begin
                        state_d = ST_IDLE;
                    end else if (exp0) begin
                        state_d = ST_IDLE;
                        rx_ab   = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        pll_load_p_d   = (state_q == ST_IDLE) &&
                         ((state_d == ST_PLL_TX) || (state_d == ST_PLL_RX));
        pll_is_tx_d    = pll_load_p_d ? (state_d == ST_PLL_TX) : pll_is_tx_q;
        tx_en_d        = (state_d == ST_TX);
        rx_en_d        = (state_d == ST_RX_SEARCH) || (state_d == ST_RX_ACTIVE);
        tx_start_p_d   = (state_q == ST_PLL_TX) && (state_d == ST_TX);
        tx_done_p_d    = tx_fin;
        rx_timeout_p_d = rx_to;
        rx_abort_p_d   = rx_ab;
    end

    assign bus.pll_load_p   = pll_load_p_q;
    assign bus.pll_is_tx    = pll_is_tx_q;
    assign bus.tx_en        = tx_en_q;
    assign bus.rx_en        = rx_en_q;
    assign bus.tx_start_p   = tx_start_p_q;
    assign bus.tx_done_p    = tx_done_p_q;
    assign bus.rx_timeout_p = rx_timeout_p_q;
    assign bus.rx_abort_p   = rx_abort_p_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_slot_txrx_ctrl.sv
// tb/tb_slot_txrx_ctrl.sv - scoreboard bench for slot_txrx_ctrl
module tb_slot_txrx_ctrl;

    logic clk_6M = 1'b0;
    logic rst    = 1'b1;

    slot_txrx_ctrl_if bus ();

    slot_txrx_ctrl dut (
        .clk_6M (clk_6M),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_6M = ~clk_6M;

    localparam logic [3:0] K_PLL  = 4'd1;
    localparam logic [3:0] K_TXS  = 4'd2;
    localparam logic [3:0] K_TXD  = 4'd3;
    localparam logic [3:0] K_RXTO = 4'd4;
    localparam logic [3:0] K_RXAB = 4'd5;
    localparam logic [3:0] K_TXEN = 4'd6;
    localparam logic [3:0] K_RXEN = 4'd7;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    int   tx_us = 0;
    int   rx_us = 0;
    logic tx_en_prev = 1'b0;
    logic rx_en_prev = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ev(input logic [3:0] k, input int v);
        logic [31:0] vv;
        vv = v;
        return {k, vv[27:0]};
    endfunction

    function automatic logic [31:0] outs();
        return {24'd0, bus.pll_load_p, bus.pll_is_tx, bus.tx_en, bus.rx_en,
                bus.tx_start_p, bus.tx_done_p, bus.rx_timeout_p, bus.rx_abort_p};
    endfunction

    task automatic observe(input logic [31:0] e);
        logic [31:0] x;
        if (exp_q.size() == 0) begin
            check_eq("unexpected_event", e, 32'd0);
        end else begin
            x = exp_q.pop_front();
            check_eq("event", e, x);
        end
    endtask

    always @(negedge clk_6M) begin
        if (bus.pll_load_p)   observe(ev(K_PLL, int'(bus.pll_is_tx)));
        if (bus.tx_start_p)   observe(ev(K_TXS, 0));
        if (bus.tx_done_p)    observe(ev(K_TXD, 0));
        if (bus.rx_timeout_p) observe(ev(K_RXTO, 0));
        if (bus.rx_abort_p)   observe(ev(K_RXAB, 0));
        if (bus.tx_en === 1'b1 && bus.rx_en === 1'b1)
            check_eq("tx_rx_exclusive", {30'd0, bus.tx_en, bus.rx_en}, 32'd2);
        if (bus.tx_en === 1'b1 && bus.p_1us) tx_us++;
        if (bus.rx_en === 1'b1 && bus.p_1us) rx_us++;
        if (tx_en_prev && bus.tx_en !== 1'b1) begin
            observe(ev(K_TXEN, tx_us));
            tx_us = 0;
        end
        if (rx_en_prev && bus.rx_en !== 1'b1) begin
            observe(ev(K_RXEN, rx_us));
            rx_us = 0;
        end
        tx_en_prev = (bus.tx_en === 1'b1);
        rx_en_prev = (bus.rx_en === 1'b1);
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk_6M);
        #1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            bus.p_1us = 1'b1;
            cyc();
            bus.p_1us = 1'b0;
            cyc();
        end
    endtask

    task automatic fk();
        bus.fkset_p = 1'b1;
        cyc();
        bus.fkset_p = 1'b0;
    endtask

    task automatic tx_slot();
        bus.tx_slot_start_p = 1'b1;
        cyc();
        bus.tx_slot_start_p = 1'b0;
    endtask

    task automatic rx_slot();
        bus.rx_slot_start_p = 1'b1;
        cyc();
        bus.rx_slot_start_p = 1'b0;
    endtask

    task automatic drain(input string tag);
        cyc(4);
        check_eq(tag, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        bus.regi_isMaster   = 1'b1;
        bus.conn_en         = 1'b1;
        bus.p_1us           = 1'b0;
        bus.fkset_p         = 1'b0;
        bus.clk_bits        = 2'b00;
        bus.tx_slot_start_p = 1'b0;
        bus.rx_slot_start_p = 1'b0;
        bus.tx_req          = 1'b0;
        bus.tx_len_us       = 12'd0;
        bus.rx_sync_p       = 1'b0;
        bus.rx_done_p       = 1'b0;
        bus.regi_rxwin_us   = 10'd0;

        cyc(3);
        check_eq("reset_outs", outs(), 32'd0);
        check_eq("reset_state", {29'd0, bus.state}, 32'd0);
        rst = 1'b0;
        cyc(2);

        // Half-slot fkset must not start anything.
        bus.tx_req    = 1'b1;
        bus.tx_len_us = 12'd10;
        bus.clk_bits  = 2'b10;
        fk();
        cyc();
        check_eq("half_slot_ignored", {29'd0, bus.state}, 32'd0);
        drain("half_slot_pending");

        // Master single-slot TX of 366 us.
        bus.tx_len_us = 12'd366;
        bus.clk_bits  = 2'b11;
        exp_q.push_back(ev(K_PLL, 1));
        exp_q.push_back(ev(K_TXS, 0));
        exp_q.push_back(ev(K_TXD, 0));
        exp_q.push_back(ev(K_TXEN, 366));
        fk();
        check_eq("pll_tx_state", {29'd0, bus.state}, 32'd1);
        bus.tx_req    = 1'b0;
        bus.tx_len_us = 12'd5;
        cyc(2);
        tx_slot();
        tick(366);
        check_eq("tx366_idle", {29'd0, bus.state}, 32'd0);
        drain("tx366_pending");

        // Slave RX, no sync, 20 us window.
        bus.regi_isMaster = 1'b0;
        bus.clk_bits      = 2'b01;
        bus.regi_rxwin_us = 10'd20;
        exp_q.push_back(ev(K_PLL, 0));
        exp_q.push_back(ev(K_RXTO, 0));
        exp_q.push_back(ev(K_RXEN, 20));
        fk();
        check_eq("pll_rx_state", {29'd0, bus.state}, 32'd3);
        rx_slot();
        tick(20);
        check_eq("rxto_idle", {29'd0, bus.state}, 32'd0);
        drain("rxto_pending");

        // Master 5-slot TX, length saturates, stray pulses ignored.
        bus.regi_isMaster = 1'b1;
        bus.clk_bits      = 2'b11;
        bus.tx_req        = 1'b1;
        bus.tx_len_us     = 12'd3500;
        exp_q.push_back(ev(K_PLL, 1));
        exp_q.push_back(ev(K_TXS, 0));
        exp_q.push_back(ev(K_TXD, 0));
        exp_q.push_back(ev(K_TXEN, 3125));
        fk();
        tx_slot();
        for (int i = 0; i < 3125; i++) begin
            bus.p_1us = 1'b1;
            cyc();
            bus.p_1us = 1'b0;
            if (i % 100 == 50) begin
                bus.fkset_p         = 1'b1;
                bus.tx_slot_start_p = 1'b1;
                bus.rx_slot_start_p = 1'b1;
            end
            cyc();
            bus.fkset_p         = 1'b0;
            bus.tx_slot_start_p = 1'b0;
            bus.rx_slot_start_p = 1'b0;
            if (i == 3123) check_eq("multislot_still_tx", {29'd0, bus.state}, 32'd2);
        end
        check_eq("multislot_idle", {29'd0, bus.state}, 32'd0);
        drain("multislot_pending");

        // Sync on the same tick the window expires: sync wins.
        bus.regi_isMaster = 1'b0;
        bus.clk_bits      = 2'b01;
        bus.tx_req        = 1'b0;
        exp_q.push_back(ev(K_PLL, 0));
        exp_q.push_back(ev(K_RXEN, 30));
        fk();
        rx_slot();
        tick(19);
        bus.p_1us     = 1'b1;
        bus.rx_sync_p = 1'b1;
        cyc();
        bus.p_1us     = 1'b0;
        bus.rx_sync_p = 1'b0;
        cyc();
        check_eq("sync_wins_state", {29'd0, bus.state}, 32'd5);
        tick(10);
        bus.rx_done_p = 1'b1;
        cyc();
        bus.rx_done_p = 1'b0;
        check_eq("rx_done_rx_en", {31'd0, bus.rx_en}, 32'd0);
        drain("sync_wins_pending");

        // conn_en dropped mid-TX.
        bus.regi_isMaster = 1'b1;
        bus.clk_bits      = 2'b11;
        bus.tx_req        = 1'b1;
        bus.tx_len_us     = 12'd100;
        exp_q.push_back(ev(K_PLL, 1));
        exp_q.push_back(ev(K_TXS, 0));
        exp_q.push_back(ev(K_TXEN, 40));
        fk();
        tx_slot();
        tick(40);
        bus.conn_en = 1'b0;
        cyc();
        check_eq("conn_off_tx_en", {31'd0, bus.tx_en}, 32'd0);
        check_eq("conn_off_state", {29'd0, bus.state}, 32'd0);
        tick(70);
        bus.conn_en = 1'b1;
        drain("conn_off_pending");

        // rst during RX_ACTIVE.
        bus.regi_isMaster = 1'b0;
        bus.clk_bits      = 2'b01;
        bus.tx_req        = 1'b0;
        exp_q.push_back(ev(K_PLL, 0));
        exp_q.push_back(ev(K_RXEN, 8));
        fk();
        rx_slot();
        tick(3);
        bus.rx_sync_p = 1'b1;
        cyc();
        bus.rx_sync_p = 1'b0;
        tick(5);
        check_eq("pre_rst_active", {29'd0, bus.state}, 32'd5);
        rst = 1'b1;
        cyc();
        check_eq("rst_mid_outs", outs(), 32'd0);
        check_eq("rst_mid_state", {29'd0, bus.state}, 32'd0);
        rst = 1'b0;
        drain("rst_mid_pending");

        // Watchdog: no slot start after fk_full.
        exp_q.push_back(ev(K_PLL, 0));
        fk();
        tick(624);
        check_eq("wdog_624", {29'd0, bus.state}, 32'd3);
        tick(1);
        check_eq("wdog_625", {29'd0, bus.state}, 32'd0);
        drain("wdog_pending");

        // Normal shortest TX right after the watchdog.
        bus.regi_isMaster = 1'b1;
        bus.clk_bits      = 2'b11;
        bus.tx_req        = 1'b1;
        bus.tx_len_us     = 12'd1;
        exp_q.push_back(ev(K_PLL, 1));
        exp_q.push_back(ev(K_TXS, 0));
        exp_q.push_back(ev(K_TXD, 0));
        exp_q.push_back(ev(K_TXEN, 1));
        fk();
        tx_slot();
        tick(1);
        check_eq("tx1_idle", {29'd0, bus.state}, 32'd0);
        drain("tx1_pending");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
